// File: rtl/piled_array_splitter_stream.sv
// Splits one piled word of NELEM interleaved elements into per-channel lane groups.
// Latency: group 0 of a word accepted at cycle T is presented at T+1; one group per cycle.
// Backpressure: valid/ready on both sides; outputs hold while stalled, next word accepted on the last group.
module piled_array_splitter_stream #(
    parameter int ELEM_W = 8,
    parameter int MAX_CH = 4,
    parameter int NELEM  = 12
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic [2:0]                ch_num,
    input  logic [NELEM*ELEM_W-1:0]   in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [MAX_CH*ELEM_W-1:0]  out_data,
    output logic [MAX_CH-1:0]         out_mask,
    output logic                      out_last,
    output logic                      out_valid,
    input  logic                      out_ready
);

    localparam int CH_W = $clog2(MAX_CH + 1);
    localparam int G_W  = $clog2(NELEM + 1);

    typedef enum logic {IDLE, EMIT} state_t;

    state_t                  state_q, state_d;
    logic [NELEM*ELEM_W-1:0] word_q;
    logic [CH_W-1:0]         ch_q, ch_legal;
    logic [G_W-1:0]          g_q;
    logic                    last_q;
    logic                    accept, advance;

    function automatic int groups_for(input logic [CH_W-1:0] ch);
        int n;
        n = NELEM;
        for (int c = 1; c <= MAX_CH; c++) begin
            if (int'(ch) == c) n = (NELEM + c - 1) / c;
        end
        return n;
    endfunction

    always_comb begin
        if (ch_num == 3'd0)
            ch_legal = CH_W'(1);
        else if (32'(ch_num) > MAX_CH)
            ch_legal = CH_W'(MAX_CH);
        else
            ch_legal = CH_W'(ch_num);
    end

    assign accept  = in_valid & in_ready;
    assign advance = out_valid & out_ready & ~last_q & ~flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (accept) state_d = EMIT;
                EMIT:    if (out_ready && last_q) state_d = in_valid ? EMIT : IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Word, channel count, group index and last flag move together so out_last stays registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q <= '0;
            ch_q   <= '0;
            g_q    <= '0;
            last_q <= 1'b0;
        end else if (flush) begin
            word_q <= '0;
            g_q    <= '0;
            last_q <= 1'b0;
        end else if (accept) begin
            word_q <= in_data;
            ch_q   <= ch_legal;
            g_q    <= '0;
            last_q <= (groups_for(ch_legal) == 1);
        end else if (advance) begin
            g_q    <= g_q + G_W'(1);
            last_q <= (int'(g_q) + 2 == groups_for(ch_q));
        end else if (out_valid && out_ready) begin
            last_q <= 1'b0;
        end
    end

    always_comb begin
        int idx;
        out_valid = (state_q == EMIT);
        out_last  = out_valid & last_q;
        in_ready  = ~flush & ((state_q == IDLE) | (out_valid & out_ready & last_q));
        out_data  = '0;
        out_mask  = '0;
        for (int c = 0; c < MAX_CH; c++) begin
            idx = int'(g_q) * int'(ch_q) + c;
            if (out_valid && c < int'(ch_q) && idx < NELEM) begin
                out_mask[c] = 1'b1;
                for (int e = 0; e < NELEM; e++) begin
                    if (idx == e) out_data[c*ELEM_W +: ELEM_W] = word_q[e*ELEM_W +: ELEM_W];
                end
            end
        end
    end

endmodule

// File: tb/tb_piled_array_splitter_stream.sv
// Directed bench for piled_array_splitter_stream: NELEM=12 instance plus a NELEM=10 instance.
module tb_piled_array_splitter_stream;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  ch_num = 3'd0;
    logic [95:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] out_data;
    logic [3:0]  out_mask;
    logic        out_last, out_valid;
    logic        out_ready = 1'b0;

    logic        b_flush = 1'b0;
    logic [2:0]  b_ch_num = 3'd0;
    logic [79:0] b_in_data = '0;
    logic        b_in_valid = 1'b0;
    logic        b_in_ready;
    logic [31:0] b_out_data;
    logic [3:0]  b_out_mask;
    logic        b_out_last, b_out_valid;
    logic        b_out_ready = 1'b1;

    int n_chk = 0;
    int n_fail = 0;

    logic [31:0] exp1 [4] = '{32'h00020100, 32'h00050403, 32'h00080706, 32'h000B0A09};
    logic [31:0] exp2 [6] = '{32'h13121110, 32'h17161514, 32'h1B1A1918,
                              32'h23222120, 32'h27262524, 32'h2B2A2928};
    logic [31:0] exp3 [6] = '{32'h00003130, 32'h00003332, 32'h00003534,
                              32'h00003736, 32'h00003938, 32'h00003B3A};
    logic [31:0] exp6 [3] = '{32'h83828180, 32'h87868584, 32'h00008988};
    logic [3:0]  msk6 [3] = '{4'b1111, 4'b1111, 4'b0011};

    piled_array_splitter_stream #(.ELEM_W(8), .MAX_CH(4), .NELEM(12)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .ch_num(ch_num),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_mask(out_mask), .out_last(out_last),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    piled_array_splitter_stream #(.ELEM_W(8), .MAX_CH(4), .NELEM(10)) dut10 (
        .clk(clk), .rst_n(rst_n), .flush(b_flush), .ch_num(b_ch_num),
        .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .out_data(b_out_data), .out_mask(b_out_mask), .out_last(b_out_last),
        .out_valid(b_out_valid), .out_ready(b_out_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_grp(input string tag, input logic vld, input logic [31:0] d,
                           input logic [3:0] m, input logic l,
                           input logic [31:0] ed, input logic [3:0] em, input logic el);
        chk({tag, "_vld"}, 32'(vld), 32'd1);
        chk({tag, "_dat"}, d, ed);
        chk({tag, "_msk"}, 32'(m), 32'(em));
        chk({tag, "_lst"}, 32'(l), 32'(el));
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [95:0] word12(input logic [7:0] base);
        logic [95:0] w;
        for (int i = 0; i < 12; i++) w[i*8 +: 8] = base + 8'(i);
        return w;
    endfunction

    initial begin
        int gi;
        out_ready = 1'b1;
        #2;
        chk("rst_vld", 32'(out_valid), 32'd0);
        chk("rst_dat", out_data, 32'd0);
        chk("rst_msk", 32'(out_mask), 32'd0);
        chk("rst_lst", 32'(out_last), 32'd0);
        chk("rst_inrdy", 32'(in_ready), 32'd1);
        #10 rst_n = 1'b1;

        // CH=3, one word; ch_num changed mid-word must be ignored
        cyc();
        in_valid = 1'b1; in_data = word12(8'h00); ch_num = 3'd3;
        #1 chk("t1_inrdy", 32'(in_ready), 32'd1);
        cyc();
        in_valid = 1'b0; ch_num = 3'd1;
        #1;
        for (int g = 0; g < 4; g++) begin
            chk_grp($sformatf("t1_g%0d", g), out_valid, out_data, out_mask, out_last,
                    exp1[g], 4'b0111, g == 3);
            cyc(); #1;
        end
        chk("t1_idle", 32'(out_valid), 32'd0);

        // CH=4, two words back-to-back with no bubble
        cyc();
        in_valid = 1'b1; in_data = word12(8'h10); ch_num = 3'd4;
        #1;
        cyc();
        in_data = word12(8'h20);
        #1;
        for (int i = 0; i < 6; i++) begin
            chk_grp($sformatf("t2_g%0d", i), out_valid, out_data, out_mask, out_last,
                    exp2[i], 4'b1111, (i == 2) || (i == 5));
            chk($sformatf("t2_inrdy%0d", i), 32'(in_ready), 32'((i == 2) || (i == 5)));
            cyc();
            if (i == 2) in_valid = 1'b0;
            #1;
        end
        chk("t2_idle", 32'(out_valid), 32'd0);

        // CH=2 with out_ready pattern 1,0,0,...
        cyc();
        in_valid = 1'b1; in_data = word12(8'h30); ch_num = 3'd2;
        cyc();
        in_valid = 1'b0;
        gi = 0;
        for (int k = 0; k < 40 && gi < 6; k++) begin
            out_ready = (k % 3 == 0);
            #1;
            chk_grp($sformatf("t3_k%0d", k), out_valid, out_data, out_mask, out_last,
                    exp3[gi], 4'b0011, gi == 5);
            cyc();
            if (out_ready) gi++;
        end
        chk("t3_groups", 32'(gi), 32'd6);
        out_ready = 1'b1;
        #1 chk("t3_idle", 32'(out_valid), 32'd0);

        // flush at g=1 with a competing input word
        cyc();
        in_valid = 1'b1; in_data = word12(8'h40); ch_num = 3'd3;
        cyc();
        in_valid = 1'b0;
        #1 chk_grp("t4_g0", out_valid, out_data, out_mask, out_last, 32'h00424140, 4'b0111, 1'b0);
        cyc();
        flush = 1'b1; in_valid = 1'b1; in_data = word12(8'h50); ch_num = 3'd4;
        #1;
        chk_grp("t4_g1", out_valid, out_data, out_mask, out_last, 32'h00454443, 4'b0111, 1'b0);
        chk("t4_inrdy_flush", 32'(in_ready), 32'd0);
        cyc();
        flush = 1'b0; in_valid = 1'b0;
        #1;
        chk("t4_vld", 32'(out_valid), 32'd0);
        chk("t4_dat", out_data, 32'd0);
        chk("t4_msk", 32'(out_mask), 32'd0);
        chk("t4_inrdy", 32'(in_ready), 32'd1);

        // asynchronous reset mid-word
        cyc();
        in_valid = 1'b1; in_data = word12(8'h60); ch_num = 3'd4;
        cyc();
        in_valid = 1'b0;
        #1 chk_grp("t5_g0", out_valid, out_data, out_mask, out_last, 32'h63626160, 4'b1111, 1'b0);
        cyc();
        #1 chk_grp("t5_g1", out_valid, out_data, out_mask, out_last, 32'h67666564, 4'b1111, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_vld", 32'(out_valid), 32'd0);
        chk("t5_rst_dat", out_data, 32'd0);
        chk("t5_rst_msk", 32'(out_mask), 32'd0);
        chk("t5_rst_lst", 32'(out_last), 32'd0);
        #2 rst_n = 1'b1;
        cyc();
        chk("t5_inrdy", 32'(in_ready), 32'd1);
        chk("t5_vld", 32'(out_valid), 32'd0);

        // NELEM=10: ch_num=0 -> single lane; ch_num=7 -> 4 lanes with partial last group
        cyc();
        b_in_valid = 1'b1; b_in_data = 80'(word12(8'h70)); b_ch_num = 3'd0;
        cyc();
        b_in_valid = 1'b0; b_ch_num = 3'd7;
        #1;
        for (int g = 0; g < 10; g++) begin
            chk_grp($sformatf("t6a_g%0d", g), b_out_valid, b_out_data, b_out_mask, b_out_last,
                    {24'h0, 8'h70 + 8'(g)}, 4'b0001, g == 9);
            cyc(); #1;
        end
        chk("t6a_idle", 32'(b_out_valid), 32'd0);
        b_in_valid = 1'b1; b_in_data = 80'(word12(8'h80));
        cyc();
        b_in_valid = 1'b0;
        #1;
        for (int g = 0; g < 3; g++) begin
            chk_grp($sformatf("t6b_g%0d", g), b_out_valid, b_out_data, b_out_mask, b_out_last,
                    exp6[g], msk6[g], g == 2);
            cyc(); #1;
        end
        chk("t6b_idle", 32'(b_out_valid), 32'd0);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
